spi_con_multi: RTL and testbench

Parametrised multi-device SPI controller that replaces the single-mode, single-word controller. It adds all four SPI modes (CPOL/CPHA), NUM_CS chip selects and multi-word bursts under one chip-select assertion. Upstream logic, such as the ADC/DAC configuration sequencers, uses it to read or write peripheral registers through a word-level handshake.

---
 rtl/spi_con_multi.sv | 146 ++++++++++++++
 tb/tb_spi_con_multi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_con_multi.sv
// Multi-device SPI controller: all four CPOL/CPHA modes, NUM_CS active-low selects,
// and bursts of up to MAX_WORDS words under one chip-select assertion.
module spi_con_multi #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_CS          = 4,
  parameter int DATA_CLK_PERIOD = 100,
  parameter int MAX_WORDS       = 4,
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int NW_W = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  input  logic [CS_W-1:0]       cs_sel_in,
  input  logic [1:0]            mode_in,
  input  logic [NW_W-1:0]       num_words_in,
  output logic                  ready_out,
  output logic                  word_taken_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  chip_data_out,
  input  logic                  chip_data_in,
  output logic                  chip_clk_out,
  output logic [NUM_CS-1:0]     chip_sel_out
);

  localparam int H     = DATA_CLK_PERIOD / 2;
  localparam int CNT_W = (H > 1) ? $clog2(H) : 1;
  localparam int BC_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H - 1);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [BC_W-1:0]       bit_cnt;
  logic [NW_W-1:0]       words_rem;
  logic                  lead_done, word_req, cpol, cpha, dclk_q, copi_q;
  logic [NUM_CS-1:0]     cs_n_q;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, tx_cur, rx_nxt;
  logic                  accept, tick, lead_edge, trail_edge, word_end, burst_end, sample;

  function automatic logic [NW_W-1:0] clamp_words(input logic [NW_W-1:0] n);
    if (n == '0) return NW_W'(1);
    if (int'(n) > MAX_WORDS) return NW_W'(MAX_WORDS);
    return n;
  endfunction

  always_comb begin
    accept     = (state == IDLE) && trigger_in && (int'(cs_sel_in) < NUM_CS);
    tick       = (cnt == CNT_LAST);
    lead_edge  = tick && ((state == SETUP) || ((state == XFER) && !lead_done));
    trail_edge = tick && (state == XFER) && lead_done;
    word_end   = trail_edge && (bit_cnt == BIT_LAST);
    burst_end  = word_end && (words_rem == '0);
    sample     = (lead_edge && !cpha) || (trail_edge && cpha);
    // A word requested at a boundary is used directly from data_in in its capture cycle
    tx_cur     = word_req ? data_in : tx_sr;
    rx_nxt     = sample ? {rx_sr[DATA_WIDTH-2:0], chip_data_in} : rx_sr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SETUP;
      SETUP:   if (tick)      state_nxt = XFER;
      XFER:    if (burst_end) state_nxt = HOLD;
      HOLD:    if (tick)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt            <= '0;
      bit_cnt        <= '0;
      words_rem      <= '0;
      lead_done      <= 1'b0;
      word_req       <= 1'b0;
      cpol           <= 1'b0;
      cpha           <= 1'b0;
      dclk_q         <= 1'b0;
      copi_q         <= 1'b0;
      cs_n_q         <= '1;
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else begin
      cnt            <= ((state == IDLE) || tick) ? '0 : cnt + 1'b1;
      word_req       <= 1'b0;
      data_valid_out <= 1'b0;
      if (state == IDLE) dclk_q <= mode_in[1];
      if (accept) begin
        cpol      <= mode_in[1];
        cpha      <= mode_in[0];
        words_rem <= clamp_words(num_words_in) - 1'b1;
        bit_cnt   <= '0;
        lead_done <= 1'b0;
        cs_n_q    <= ~(NUM_CS'(1) << cs_sel_in);
        if (!mode_in[0]) copi_q <= data_in[DATA_WIDTH-1];
      end
      if (word_req && !cpha) copi_q <= data_in[DATA_WIDTH-1];
      if (lead_edge) begin
        dclk_q    <= ~cpol;
        lead_done <= 1'b1;
        if (cpha) copi_q <= tx_cur[DATA_WIDTH-1];
      end
      if (trail_edge) begin
        dclk_q    <= cpol;
        lead_done <= 1'b0;
        bit_cnt   <= word_end ? '0 : bit_cnt + 1'b1;
        if (!cpha) copi_q <= tx_cur[DATA_WIDTH-2];
        if (word_end) begin
          data_out       <= rx_nxt;
          data_valid_out <= 1'b1;
          if (words_rem != '0) begin
            word_req  <= 1'b1;
            words_rem <= words_rem - 1'b1;
          end
        end
      end
      if ((state == HOLD) && tick) cs_n_q <= '1;
    end
  end

  // Shift registers carry no reset: every bit is rewritten before it is observed
  always_ff @(posedge clk_in) begin
    if (accept || word_req) tx_sr <= data_in;
    if ((lead_edge && cpha) || (trail_edge && !cpha)) tx_sr <= tx_cur << 1;
    rx_sr <= rx_nxt;
  end

  assign ready_out      = (state == IDLE);
  assign word_taken_out = rst_n_in && (accept || word_req);
  assign chip_data_out  = (word_req && !cpha) ? data_in[DATA_WIDTH-1] : copi_q;
  assign chip_clk_out   = dclk_q;
  assign chip_sel_out   = cs_n_q;

endmodule

// File: tb/tb_spi_con_multi.sv
// Directed bench for spi_con_multi: vector table of bursts plus hand sequences for
// out-of-range select, reset mid-burst and a trigger held across completion.
`timescale 1ns/1ps
module tb_spi_con_multi;
  localparam int DW = 8, NCS = 3, DCP = 4, MW = 4, H = DCP / 2;

  logic          clk_in = 1'b0, rst_n_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          trigger_in = 1'b0;
  logic [1:0]    cs_sel_in = '0;
  logic [1:0]    mode_in = '0;
  logic [2:0]    num_words_in = 3'd1;
  logic          ready_out, word_taken_out, data_valid_out, chip_data_out, chip_clk_out;
  logic [DW-1:0] data_out;
  logic [NCS-1:0] chip_sel_out;
  logic          chip_data_in;
  logic          loop_en = 1'b1, slave_cipo = 1'b0;
  int            cyc = 0, total = 0, passed = 0;

  spi_con_multi #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DATA_CLK_PERIOD(DCP), .MAX_WORDS(MW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .trigger_in(trigger_in),
    .cs_sel_in(cs_sel_in), .mode_in(mode_in), .num_words_in(num_words_in),
    .ready_out(ready_out), .word_taken_out(word_taken_out), .data_out(data_out),
    .data_valid_out(data_valid_out), .chip_data_out(chip_data_out),
    .chip_data_in(chip_data_in), .chip_clk_out(chip_clk_out), .chip_sel_out(chip_sel_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  assign chip_data_in = loop_en ? chip_data_out : slave_cipo;

  // Peripheral model answering 0xC3, changing CIPO on the edge opposite to sampling
  logic       s_act = 1'b0, s_prev = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0;
  logic [7:0] s_sr = '0;
  always @(negedge clk_in) begin
    s_prev <= chip_clk_out;
    if (&chip_sel_out) s_act <= 1'b0;
    else if (!s_act) begin
      s_act <= 1'b1;
      if (s_cpha) s_sr <= 8'hC3;
      else begin
        slave_cipo <= 1'b1;
        s_sr       <= 8'h86;
      end
    end else if ((chip_clk_out != s_prev) && ((chip_clk_out != s_cpol) == s_cpha)) begin
      slave_cipo <= s_sr[7];
      s_sr       <= {s_sr[6:0], 1'b0};
    end
  end

  typedef struct packed {
    logic [1:0]      mode;
    logic [1:0]      cs;
    logic [2:0]      nw;
    logic            loop;
    logic            busy_trig;
    logic [2:0]      exp_cs;
    logic [3:0][7:0] tx;
    int              exp_n;
    int              exp_end;
    logic [3:0][7:0] rx;
  } vec_t;

  vec_t vecs[7];
  vec_t post_rst;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic run_burst(input vec_t v, input string nm);
    int   t0, rel, widx, nwt, ndv, nlead, cs_bad, edge_bad, end_rel;
    logic prev_clk, wt_now;
    mode_in = v.mode; cs_sel_in = v.cs; num_words_in = v.nw; loop_en = v.loop;
    s_cpol = v.mode[1]; s_cpha = v.mode[0];
    repeat (2) @(posedge clk_in);
    #1;
    check({nm, "_idle_clk"}, chip_clk_out, v.mode[1]);
    check({nm, "_ready"}, ready_out, 1);
    data_in = v.tx[0]; widx = 0; trigger_in = 1'b1; t0 = cyc;
    nwt = 0; ndv = 0; nlead = 0; cs_bad = 0; edge_bad = 0; end_rel = -1;
    prev_clk = chip_clk_out;
    for (int i = 0; i < 400 && end_rel < 0; i++) begin
      @(negedge clk_in);
      rel = cyc - t0;
      wt_now = word_taken_out;
      if (wt_now) begin
        if (rel != ((nwt == 0) ? 0 : 1 + 2 * H * DW * nwt)) edge_bad++;
        nwt++;
      end
      if (data_valid_out) begin
        if (ndv < 4) check($sformatf("%s_rx%0d", nm, ndv), data_out, v.rx[ndv]);
        if (rel != 1 + 2 * H * DW * (ndv + 1)) edge_bad++;
        ndv++;
      end
      if ((chip_clk_out != prev_clk) && (chip_clk_out != v.mode[1])) begin
        if (rel != 1 + H + 2 * H * nlead) edge_bad++;
        nlead++;
      end
      prev_clk = chip_clk_out;
      if (rel >= 1) begin
        if (ready_out) begin
          end_rel = rel;
          if (chip_sel_out != '1) cs_bad++;
        end else if (chip_sel_out != v.exp_cs) cs_bad++;
      end
      @(posedge clk_in);
      #1;
      if (rel == 0) trigger_in = 1'b0;
      if (v.busy_trig && rel == 9) begin
        trigger_in = 1'b1; cs_sel_in = 2'd0; data_in = 8'hFF;
      end
      if (v.busy_trig && rel == 10) begin
        trigger_in = 1'b0; cs_sel_in = v.cs;
      end
      if (wt_now && widx < 3) begin
        widx++;
        data_in = v.tx[widx];
      end
    end
    check({nm, "_end_cycle"}, end_rel, v.exp_end);
    check({nm, "_word_taken_cnt"}, nwt, v.exp_n);
    check({nm, "_valid_cnt"}, ndv, v.exp_n);
    check({nm, "_dclk_pulses"}, nlead, DW * v.exp_n);
    check({nm, "_cs_pattern_bad"}, cs_bad, 0);
    check({nm, "_timing_bad"}, edge_bad, 0);
    check({nm, "_end_clk"}, chip_clk_out, v.mode[1]);
  endtask

  initial begin
    int   t0, rel, widx, ndv, bad, first_rdy, second_rdy, busy_after, dv_n;
    logic wt_now, wt_at_rdy;
    int   dv_rel[2];
    logic [7:0] dv_val[2];

    //            mode   cs    nw    loop  busy  exp_cs   tx            n  end  rx
    vecs[0] = '{2'd0, 2'd0, 3'd1, 1'b1, 1'b0, 3'b110, 32'h000000A5, 1, 35,  32'h000000A5};
    vecs[1] = '{2'd3, 2'd1, 3'd3, 1'b1, 1'b0, 3'b101, 32'h00563412, 3, 99,  32'h00563412};
    vecs[2] = '{2'd1, 2'd2, 3'd1, 1'b0, 1'b0, 3'b011, 32'h0000000F, 1, 35,  32'h000000C3};
    vecs[3] = '{2'd2, 2'd0, 3'd1, 1'b0, 1'b0, 3'b110, 32'h000000F0, 1, 35,  32'h000000C3};
    vecs[4] = '{2'd0, 2'd1, 3'd0, 1'b1, 1'b1, 3'b101, 32'h0000993C, 1, 35,  32'h0000003C};
    vecs[5] = '{2'd1, 2'd2, 3'd5, 1'b1, 1'b0, 3'b011, 32'h44332211, 4, 131, 32'h44332211};
    vecs[6] = '{2'd2, 2'd1, 3'd2, 1'b1, 1'b0, 3'b101, 32'h00007E81, 2, 67,  32'h00007E81};
    post_rst = '{2'd1, 2'd0, 3'd1, 1'b1, 1'b0, 3'b110, 32'h0000005A, 1, 35, 32'h0000005A};

    repeat (3) @(negedge clk_in);
    check("rst_ready", ready_out, 1);
    check("rst_cs", chip_sel_out, 3'b111);
    check("rst_dclk", chip_clk_out, 0);
    check("rst_copi", chip_data_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid_out, 0);
    check("rst_word_taken", word_taken_out, 0);
    rst_n_in = 1'b1;

    for (int i = 0; i < 7; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // Out-of-range chip select is ignored
    mode_in = 2'd0; cs_sel_in = 2'd3; num_words_in = 3'd1;
    repeat (2) @(posedge clk_in);
    #1;
    trigger_in = 1'b1; bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (!ready_out || chip_sel_out != 3'b111 || word_taken_out || chip_clk_out) bad++;
      @(posedge clk_in);
      #1;
    end
    trigger_in = 1'b0;
    check("cs_range_ignored_bad", bad, 0);
    check("cs_range_ready", ready_out, 1);

    // Reset in the middle of the second word
    mode_in = 2'd0; cs_sel_in = 2'd2; num_words_in = 3'd3; loop_en = 1'b1; data_in = 8'h12;
    repeat (2) @(posedge clk_in);
    #1;
    trigger_in = 1'b1; t0 = cyc; ndv = 0; widx = 0;
    for (int i = 0; i < 49; i++) begin
      @(negedge clk_in);
      if (data_valid_out) ndv++;
      wt_now = word_taken_out;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      if (wt_now) begin
        widx++;
        data_in = (widx == 1) ? 8'h34 : 8'h56;
      end
    end
    check("midrst_valid_before", ndv, 1);
    @(negedge clk_in);
    check("midrst_busy", ready_out, 0);
    rst_n_in = 1'b0;
    #1;
    check("midrst_ready", ready_out, 1);
    check("midrst_cs", chip_sel_out, 3'b111);
    check("midrst_dclk", chip_clk_out, 0);
    check("midrst_copi", chip_data_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_word_taken", word_taken_out, 0);
    ndv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      if (data_valid_out) ndv++;
    end
    check("midrst_valid_after", ndv, 0);
    rst_n_in = 1'b1;
    run_burst(post_rst, "post_reset");

    // Trigger held high across completion starts the next burst immediately
    mode_in = 2'd0; cs_sel_in = 2'd1; num_words_in = 3'd1; loop_en = 1'b1; data_in = 8'h66;
    repeat (2) @(posedge clk_in);
    #1;
    trigger_in = 1'b1; t0 = cyc; first_rdy = -1; second_rdy = -1; busy_after = 0;
    wt_at_rdy = 1'b0; dv_n = 0; dv_rel[0] = -1; dv_rel[1] = -1; dv_val[0] = '0; dv_val[1] = '0;
    for (int i = 0; i < 200 && second_rdy < 0; i++) begin
      @(negedge clk_in);
      rel = cyc - t0;
      if (data_valid_out && dv_n < 2) begin
        dv_rel[dv_n] = rel; dv_val[dv_n] = data_out; dv_n++;
      end
      if (first_rdy >= 0 && rel > first_rdy + 1 && ready_out) second_rdy = rel;
      if (first_rdy >= 0 && rel == first_rdy + 1)
        busy_after = (!ready_out && chip_sel_out == 3'b101) ? 1 : 0;
      if (rel >= 1 && ready_out && first_rdy < 0) begin
        first_rdy = rel; wt_at_rdy = word_taken_out;
      end
      @(posedge clk_in);
      #1;
      if (rel == 0) data_in = 8'h77;
      if (first_rdy >= 0 && rel == first_rdy) trigger_in = 1'b0;
    end
    trigger_in = 1'b0;
    check("held_first_ready", first_rdy, 35);
    check("held_word_taken_at_ready", wt_at_rdy, 1);
    check("held_restart_busy", busy_after, 1);
    check("held_dv0_val", dv_val[0], 8'h66);
    check("held_dv0_cycle", dv_rel[0], 33);
    check("held_dv1_val", dv_val[1], 8'h77);
    check("held_dv1_cycle", dv_rel[1], 68);
    check("held_second_ready", second_rdy, 70);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
